dmem_arbiter: RTL and testbench

// Shares the single-port 8x8 data memory between two requesters: port 0 (cpu

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of the 8x8 data memory
// between the cpu port (0) and the host port (1).
module dmem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  state_e                state_q;
  logic                  last_gnt_q;
  logic                  id_q;
  logic                  wr_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_en_q;
  logic                  mem_wr_en_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  busy_q;

  logic                  win_d;
  logic                  wr_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Pick the winner: a lone requester wins, a tie
  // goes to the port that was not granted last.
  always_comb begin
    win_d = 1'b0;
    unique case (1'b1)
      (req0 && req1):  win_d = ~last_gnt_q;
      (req1 && !req0): win_d = 1'b1;
      default:         win_d = 1'b0;
    endcase
  end

  // Route the winning port's command fields.
  always_comb begin
    wr_d    = wr0;
    addr_d  = addr0;
    wdata_d = wdata0;
    if (win_d) begin
      wr_d    = wr1;
      addr_d  = addr1;
      wdata_d = wdata1;
    end
  end

  // Arbiter FSM; every output is a register loaded
  // one cycle ahead of the state it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      id_q        <= 1'b0;
      wr_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            id_q        <= win_d;
            last_gnt_q  <= win_d;
            wr_q        <= wr_d;
            gnt0_q      <= ~win_d;
            gnt1_q      <= win_d;
            mem_addr_q  <= addr_d;
            mem_wr_en_q <= wr_d;
            mem_rd_en_q <= ~wr_d;
            if (wr_d) begin
              mem_wdata_q <= wdata_d;
            end
          end
        end
        ISSUE: begin
          if (wr_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (id_q) begin
            rdata1_q  <= mem_rdata;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= mem_rdata;
            rvalid0_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors and corner
// sequences for dmem_arbiter with a memory model.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req0, wr0, req1, wr1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, rvalid0, gnt1, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [2:0] mem_addr;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;

  logic [7:0] mem [0:7] = '{8'h10, 8'h11, 8'h12, 8'h13,
                            8'h14, 8'h15, 8'h16, 8'h17};

  int checks   = 0;
  int failures = 0;
  logic [7:0] last_rd [0:1];

  typedef struct {
    int         port;
    bit         wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] seq_exp [0:8];

  dmem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".outs"},
        {23'd0, gnt0, gnt1, rvalid0, rvalid1,
         mem_rd_en, mem_wr_en, busy, mem_addr != 3'd0,
         mem_wdata != 8'd0},
        32'd0);
    chk({nm, ".rdata"}, {16'd0, rdata0, rdata1}, 32'd0);
  endtask

  task automatic do_access(input int p, input bit w,
                           input logic [2:0] a,
                           input logic [7:0] d,
                           input logic [7:0] e);
    if (p == 0) begin
      req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
    end
    tick();
    chk("acc.gnt", {30'd0, gnt1, gnt0},
        (p == 0) ? 32'd1 : 32'd2);
    chk("acc.addr", {29'd0, mem_addr}, {29'd0, a});
    chk("acc.en", {30'd0, mem_wr_en, mem_rd_en},
        w ? 32'd2 : 32'd1);
    chk("acc.busy", {31'd0, busy}, 32'd1);
    if (w) chk("acc.wdata", {24'd0, mem_wdata}, {24'd0, d});
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("acc.idle_addr", {29'd0, mem_addr}, 32'd0);
    chk("acc.pulse_end", {29'd0, gnt0 | gnt1,
        mem_wr_en, mem_rd_en}, 32'd0);
    if (w) begin
      chk("acc.wbusy", {31'd0, busy}, 32'd0);
    end else begin
      chk("acc.rbusy", {31'd0, busy}, 32'd1);
      chk("acc.early_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
      tick();
      chk("acc.rvalid", {30'd0, rvalid1, rvalid0},
          (p == 0) ? 32'd1 : 32'd2);
      chk("acc.rdata", {24'd0, (p == 0) ? rdata0 : rdata1},
          {24'd0, e});
      chk("acc.other", {24'd0, (p == 0) ? rdata1 : rdata0},
          {24'd0, last_rd[1-p]});
      chk("acc.rdbusy", {31'd0, busy}, 32'd0);
      last_rd[p] = e;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
  endtask

  initial begin
    tbl[0] = '{0, 1'b1, 3'd3, 8'hA5, 8'h00};
    tbl[1] = '{1, 1'b0, 3'd3, 8'h00, 8'hA5};
    tbl[2] = '{0, 1'b0, 3'd3, 8'h00, 8'hA5};
    tbl[3] = '{1, 1'b1, 3'd0, 8'h5A, 8'h00};
    tbl[4] = '{0, 1'b0, 3'd0, 8'h00, 8'h5A};
    tbl[5] = '{1, 1'b0, 3'd6, 8'h00, 8'h16};
    tbl[6] = '{0, 1'b1, 3'd6, 8'hC3, 8'h00};
    tbl[7] = '{1, 1'b0, 3'd6, 8'h00, 8'hC3};
    seq_exp = '{8'h5A, 8'h11, 8'h12, 8'hA5, 8'h14,
                8'h15, 8'hC3, 8'h17, 8'h5A};

    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    rstn = 1'b0;
    #1;
    chk_all_zero("reset");
    do_reset();
    chk_all_zero("post_reset");

    for (int i = 0; i < 8; i++) begin
      do_access(tbl[i].port, tbl[i].wr, tbl[i].addr,
                tbl[i].wdata, tbl[i].exp);
    end

    // back-to-back port 0 reads 0..7 then 0 again
    req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd0;
    tick();
    for (int k = 0; k < 9; k++) begin
      chk("b2b.gnt", {31'd0, gnt0}, 32'd1);
      chk("b2b.addr", {29'd0, mem_addr}, k % 8);
      if (k == 8) req0 = 1'b0;
      else addr0 = 3'((k + 1) % 8);
      tick();
      chk("b2b.norv", {31'd0, rvalid0}, 32'd0);
      tick();
      chk("b2b.rv", {31'd0, rvalid0}, 32'd1);
      chk("b2b.data", {24'd0, rdata0}, {24'd0, seq_exp[k]});
      tick();
    end
    last_rd[0] = 8'h5A;
    chk("b2b.idle", {30'd0, gnt0, busy}, 32'd0);

    // reset in RD_WAIT drops the read
    req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd2;
    tick();
    chk("mr.gnt", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("mr.rdwait", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk_all_zero("mr.async");
    tick();
    chk_all_zero("mr.held");
    rstn = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr.quiet", {30'd0, rvalid0, busy}, 32'd0);
    end

    // same-cycle read 7 (port 0) vs write 7 (port 1)
    req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd7;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 3'd7; wdata1 = 8'h3C;
    tick();
    chk("cf.gnt0", {30'd0, gnt1, gnt0}, 32'd1);
    chk("cf.rd", {30'd0, mem_wr_en, mem_rd_en}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("cf.wait", {31'd0, gnt1}, 32'd0);
    tick();
    chk("cf.rv", {31'd0, rvalid0}, 32'd1);
    chk("cf.old", {24'd0, rdata0}, 32'h17);
    last_rd[0] = 8'h17;
    tick();
    chk("cf.gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    chk("cf.wr", {29'd0, mem_wr_en, mem_addr == 3'd7,
        mem_wdata == 8'h3C}, 32'd7);
    req1 = 1'b0;
    tick();
    do_access(0, 1'b0, 3'd7, 8'h00, 8'h3C);

    // both requesting from reset alternate 0,1,0,1
    do_reset();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd1; wdata0 = 8'hAA;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 3'd2; wdata1 = 8'hBB;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr.gnt", {30'd0, gnt1, gnt0},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr.gap", {30'd0, gnt1, gnt0}, 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    do_access(1, 1'b0, 3'd1, 8'h00, 8'hAA);
    do_access(0, 1'b0, 3'd2, 8'h00, 8'hBB);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
